// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler that time-shares one combinational ALU between two requesters.
// Each accepted operation walks IDLE -> EXEC (single ALU cycle) -> RESP (held until consumed).
module alu_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 7
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req0_valid_in,
    output logic             req0_ready_out,
    input  logic [WIDTH-1:0] req0_a_in,
    input  logic [WIDTH-1:0] req0_b_in,
    input  logic [OP_W-1:0]  req0_op_in,
    input  logic             req1_valid_in,
    output logic             req1_ready_out,
    input  logic [WIDTH-1:0] req1_a_in,
    input  logic [WIDTH-1:0] req1_b_in,
    input  logic [OP_W-1:0]  req1_op_in,
    output logic             resp_valid_out,
    input  logic             resp_ready_in,
    output logic             resp_id_out,
    output logic [WIDTH-1:0] resp_result_out,
    output logic             resp_zero_out,
    output logic             resp_overflow_out,
    output logic [WIDTH-1:0] alu_a_out,
    output logic [WIDTH-1:0] alu_b_out,
    output logic [1:0]       alu_type_out,
    output logic [1:0]       alu_shift_out,
    output logic             alu_arith_out,
    output logic [1:0]       alu_logic_out,
    input  logic [WIDTH-1:0] alu_result_in,
    input  logic             alu_zero_in,
    input  logic             alu_overflow_in,
    output logic             busy_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q;
    logic [OP_W-1:0]  op_q;
    logic             last_grant;
    logic             resp_id_q;
    logic [WIDTH-1:0] resp_result_q;
    logic             resp_zero_q, resp_overflow_q;
    logic             grant_valid, grant_id;

    // Ready is gated by reset so a held request cannot see a grant while reset is asserted.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst_in) begin
                    if (req0_valid_in && req1_valid_in) begin
                        grant_valid = 1'b1;
                        grant_id    = ~last_grant;
                    end else if (req0_valid_in) begin
                        grant_valid = 1'b1;
                    end else if (req1_valid_in) begin
                        grant_valid = 1'b1;
                        grant_id    = 1'b1;
                    end
                end
                if (grant_valid) state_next = EXEC;
            end
            EXEC:    state_next = RESP;
            RESP:    if (resp_ready_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_q             <= '0;
            b_q             <= '0;
            op_q            <= '0;
            last_grant      <= 1'b1;
            resp_id_q       <= 1'b0;
            resp_result_q   <= '0;
            resp_zero_q     <= 1'b0;
            resp_overflow_q <= 1'b0;
        end else begin
            if (grant_valid) begin
                a_q        <= grant_id ? req1_a_in  : req0_a_in;
                b_q        <= grant_id ? req1_b_in  : req0_b_in;
                op_q       <= grant_id ? req1_op_in : req0_op_in;
                last_grant <= grant_id;
                resp_id_q  <= grant_id;
            end
            if (state == EXEC) begin
                resp_result_q   <= alu_result_in;
                resp_zero_q     <= alu_zero_in;
                resp_overflow_q <= alu_overflow_in;
            end
        end
    end

    assign req0_ready_out    = grant_valid && !grant_id;
    assign req1_ready_out    = grant_valid && grant_id;
    assign resp_valid_out    = (state == RESP);
    assign resp_id_out       = resp_id_q;
    assign resp_result_out   = resp_result_q;
    assign resp_zero_out     = resp_zero_q;
    assign resp_overflow_out = resp_overflow_q;
    assign busy_out          = (state != IDLE);

    // Packed opcode: {type[1:0], shift[1:0], arith, logic[1:0]}.
    assign alu_a_out     = a_q;
    assign alu_b_out     = b_q;
    assign alu_type_out  = op_q[6:5];
    assign alu_shift_out = op_q[4:3];
    assign alu_arith_out = op_q[2];
    assign alu_logic_out = op_q[1:0];

endmodule
